// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry result buffer per functional unit, round-robin
// selection of one buffered result per cycle, registered broadcast to RS/ROB.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  localparam int SEL_W     = $clog2(NUM_FU)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_FU-1:0]                    fu_valid,
  output logic [NUM_FU-1:0]                    fu_ready,
  input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]    fu_data,
  input  logic [NUM_FU-1:0][TAG_WIDTH-1:0]     fu_tag,
  output logic                                 cdb_valid,
  output logic [DATA_WIDTH-1:0]                cdb_data,
  output logic [TAG_WIDTH-1:0]                 cdb_tag,
  output logic [SEL_W-1:0]                     cdb_sel
);

  logic [NUM_FU-1:0]                 buf_valid_q, buf_valid_d;
  logic [NUM_FU-1:0][DATA_WIDTH-1:0] buf_data_q,  buf_data_d;
  logic [NUM_FU-1:0][TAG_WIDTH-1:0]  buf_tag_q,   buf_tag_d;
  logic [SEL_W-1:0]                  rr_ptr_q,    rr_ptr_d;
  logic                              cdb_valid_q, cdb_valid_d;
  logic [DATA_WIDTH-1:0]             cdb_data_q,  cdb_data_d;
  logic [TAG_WIDTH-1:0]              cdb_tag_q,   cdb_tag_d;
  logic [SEL_W-1:0]                  cdb_sel_q,   cdb_sel_d;

  logic                              grant_vld;
  logic [SEL_W-1:0]                  grant_idx;
  logic [NUM_FU-1:0]                 grant_oh;
  logic [SEL_W-1:0]                  scan_idx;

  // Round-robin scan starting at rr_ptr; the SEL_W-bit add wraps naturally
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx = rr_ptr_q + SEL_W'(k);
      if (!grant_vld && buf_valid_q[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  // Ready depends only on buffer state and flush, never on fu_valid
  always_comb begin
    fu_ready = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = !flush && (!buf_valid_q[i] || grant_oh[i]);
    end
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_tag_d   = buf_tag_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_data_d  = cdb_data_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_sel_d   = cdb_sel_q;

    if (grant_vld && !flush) begin
      cdb_valid_d            = 1'b1;
      cdb_data_d             = buf_data_q[grant_idx];
      cdb_tag_d              = buf_tag_q[grant_idx];
      cdb_sel_d              = grant_idx;
      rr_ptr_d               = grant_idx + SEL_W'(1);
      buf_valid_d[grant_idx] = 1'b0;
    end

    // Refill after the grant clear so a drained buffer can reload at the same edge
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_valid[i] && fu_ready[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_data_d[i]  = fu_data[i];
        buf_tag_d[i]   = fu_tag[i];
      end
    end

    if (flush) buf_valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_tag_q   <= '0;
      cdb_sel_q   <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_sel_q   <= cdb_sel_d;
    end
  end

  // Payload storage is qualified by buf_valid_q, so it carries no reset
  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
    buf_tag_q  <= buf_tag_d;
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_sel   = cdb_sel_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic checked against
// a queue-free array model of the buffers, round-robin pointer and broadcast register.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 6;

  logic                    clk;
  logic                    reset;
  logic                    flush;
  logic [N-1:0]            fu_valid;
  logic [N-1:0]            fu_ready;
  logic [N-1:0][DW-1:0]    fu_data;
  logic [N-1:0][TW-1:0]    fu_tag;
  logic                    cdb_valid;
  logic [DW-1:0]           cdb_data;
  logic [TW-1:0]           cdb_tag;
  logic [1:0]              cdb_sel;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.NUM_FU(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_ready  (fu_ready),
    .fu_data   (fu_data),
    .fu_tag    (fu_tag),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_sel   (cdb_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit          m_bv [N];
  logic [DW-1:0] m_bd [N];
  logic [TW-1:0] m_bt [N];
  int          m_rr;
  bit          m_cv;
  logic [DW-1:0] m_cd;
  logic [TW-1:0] m_ct;
  logic [1:0]  m_cs;

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      if (m_bv[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    g = m_grant();
    for (int i = 0; i < N; i++) r[i] = !flush && (!m_bv[i] || g == i);
    return r;
  endfunction

  task automatic model_edge();
    int g;
    logic [N-1:0] rdy;
    g   = m_grant();
    rdy = m_ready();
    if (reset) begin
      for (int i = 0; i < N; i++) m_bv[i] = 0;
      m_rr = 0; m_cv = 0; m_cd = '0; m_ct = '0; m_cs = '0;
    end else begin
      if (flush) m_cv = 0;
      else if (g >= 0) begin
        m_cv = 1; m_cd = m_bd[g]; m_ct = m_bt[g]; m_cs = 2'(g);
        m_rr = (g + 1) % N; m_bv[g] = 0;
      end else m_cv = 0;
      for (int i = 0; i < N; i++) begin
        if (fu_valid[i] && rdy[i]) begin
          m_bv[i] = 1; m_bd[i] = fu_data[i]; m_bt[i] = fu_tag[i];
        end
      end
      if (flush) for (int i = 0; i < N; i++) m_bv[i] = 0;
    end
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; flush = 0; fu_valid = '0; fu_data = '0; fu_tag = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    advance();
    reset = 0;
    #1;
    checks++;
    if ({cdb_valid, cdb_data, cdb_tag, cdb_sel} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h t=%h s=%0d want all zero", cdb_valid, cdb_data, cdb_tag, cdb_sel);
    end
    checks++;
    if (fu_ready !== 4'hF) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1111", fu_ready);
    end
  endtask

  task automatic test_single();
    fu_valid = 4'b0100; fu_data[2] = 32'hDEADBEEF; fu_tag[2] = 6'd5;
    #1;
    checks++;
    if (fu_ready[2] !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got=%b want=1", fu_ready[2]);
    end
    advance();
    fu_valid = '0;
    checks++;
    if (cdb_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_lat1 cdb_valid got=%b want=0", cdb_valid);
    end
    advance();
    checks++;
    if ({cdb_valid, cdb_data, cdb_tag, cdb_sel} !== {1'b1, 32'hDEADBEEF, 6'd5, 2'd2}) begin
      failures++;
      $display("FAIL single_bcast got v=%b d=%h t=%0d s=%0d want v=1 d=deadbeef t=5 s=2", cdb_valid, cdb_data, cdb_tag, cdb_sel);
    end
    advance();
    checks++;
    if (cdb_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_after cdb_valid got=%b want=0", cdb_valid);
    end
  endtask

  task automatic test_all_four();
    reset = 1;
    advance();
    reset = 0;
    fu_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      fu_tag[i]  = 6'(10 + i);
      fu_data[i] = 32'h1000 + i;
    end
    advance();
    fu_valid = '0;
    for (int k = 0; k < N; k++) begin
      #1;
      checks++;
      if (fu_ready !== 4'((1 << (k + 1)) - 1)) begin
        failures++;
        $display("FAIL all4_ready[%0d] got=%b want=%b", k, fu_ready, 4'((1 << (k + 1)) - 1));
      end
      advance();
      checks++;
      if ({cdb_valid, cdb_tag, cdb_sel} !== {1'b1, 6'(10 + k), 2'(k)}) begin
        failures++;
        $display("FAIL all4_bcast[%0d] got v=%b t=%0d s=%0d want v=1 t=%0d s=%0d", k, cdb_valid, cdb_tag, cdb_sel, 10 + k, k);
      end
    end
  endtask

  task automatic test_rr_wrap();
    fu_valid = 4'b0100; fu_tag[2] = 6'd20;
    advance();
    fu_valid = 4'b1001; fu_tag[0] = 6'd21; fu_tag[3] = 6'd23;
    advance();
    fu_valid = '0;
    checks++;
    if ({cdb_valid, cdb_sel} !== {1'b1, 2'd2}) begin
      failures++;
      $display("FAIL wrap_first got v=%b s=%0d want v=1 s=2", cdb_valid, cdb_sel);
    end
    advance();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_sel} !== {1'b1, 6'd23, 2'd3}) begin
      failures++;
      $display("FAIL wrap_fu3 got v=%b t=%0d s=%0d want v=1 t=23 s=3", cdb_valid, cdb_tag, cdb_sel);
    end
    advance();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_sel} !== {1'b1, 6'd21, 2'd0}) begin
      failures++;
      $display("FAIL wrap_fu0 got v=%b t=%0d s=%0d want v=1 t=21 s=0", cdb_valid, cdb_tag, cdb_sel);
    end
    // Pointer should now be 1: FU1 must win over FU0
    fu_valid = 4'b0011; fu_tag[0] = 6'd30; fu_tag[1] = 6'd31;
    advance();
    fu_valid = '0;
    advance();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_sel} !== {1'b1, 6'd31, 2'd1}) begin
      failures++;
      $display("FAIL wrap_ptr1 got v=%b t=%0d s=%0d want v=1 t=31 s=1", cdb_valid, cdb_tag, cdb_sel);
    end
    advance();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_sel} !== {1'b1, 6'd30, 2'd0}) begin
      failures++;
      $display("FAIL wrap_ptr1_next got v=%b t=%0d s=%0d want v=1 t=30 s=0", cdb_valid, cdb_tag, cdb_sel);
    end
    advance();
  endtask

  task automatic test_streaming();
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        fu_valid = 4'b0010; fu_tag[1] = 6'(k + 1); fu_data[1] = 32'hA0 + k;
        #1;
        checks++;
        if (fu_ready[1] !== 1'b1) begin
          failures++;
          $display("FAIL stream_ready[%0d] got=%b want=1", k, fu_ready[1]);
        end
      end else fu_valid = '0;
      advance();
      if (k >= 1) begin
        checks++;
        if ({cdb_valid, cdb_tag, cdb_sel, cdb_data} !== {1'b1, 6'(k), 2'd1, 32'hA0 + k - 1}) begin
          failures++;
          $display("FAIL stream_bcast[%0d] got v=%b t=%0d s=%0d d=%h want v=1 t=%0d s=1", k, cdb_valid, cdb_tag, cdb_sel, cdb_data, k);
        end
      end
    end
    advance();
  endtask

  task automatic test_flush();
    fu_valid = 4'b1001; fu_tag[0] = 6'd40; fu_tag[3] = 6'd43;
    advance();
    flush = 1; fu_valid = 4'hF; fu_tag = {6'd63, 6'd62, 6'd61, 6'd60};
    #1;
    checks++;
    if (fu_ready !== 4'b0000) begin
      failures++;
      $display("FAIL flush_ready got=%b want=0000", fu_ready);
    end
    advance();
    flush = 0; fu_valid = '0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cdb_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_quiet[%0d] cdb_valid got=%b tag=%0d want=0", k, cdb_valid, cdb_tag);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    fu_valid = 4'hF;
    for (int i = 0; i < N; i++) fu_tag[i] = 6'(50 + i);
    advance();
    fu_valid = '0;
    advance();
    checks++;
    if (cdb_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre cdb_valid got=%b want=1", cdb_valid);
    end
    reset = 1;
    advance();
    reset = 0;
    checks++;
    if ({cdb_valid, cdb_data, cdb_tag, cdb_sel} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got v=%b d=%h t=%0d s=%0d want all zero", cdb_valid, cdb_data, cdb_tag, cdb_sel);
    end
    fu_valid = 4'b0010; fu_tag[1] = 6'd33; fu_data[1] = 32'h1234_5678;
    advance();
    fu_valid = '0;
    checks++;
    if (cdb_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_stale cdb_valid got=%b tag=%0d want=0", cdb_valid, cdb_tag);
    end
    advance();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_sel, cdb_data} !== {1'b1, 6'd33, 2'd1, 32'h1234_5678}) begin
      failures++;
      $display("FAIL rstmid_new got v=%b t=%0d s=%0d d=%h want v=1 t=33 s=1 d=12345678", cdb_valid, cdb_tag, cdb_sel, cdb_data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      reset    = ($urandom_range(0, 63) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      fu_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        fu_data[i] = $urandom;
        fu_tag[i]  = 6'($urandom);
      end
      #1;
      checks++;
      if (fu_ready !== m_ready()) begin
        failures++;
        $display("FAIL rand_ready[%0d] got=%b want=%b", c, fu_ready, m_ready());
      end
      advance();
      checks++;
      if ({cdb_valid, cdb_data, cdb_tag, cdb_sel} !== {m_cv, m_cd, m_ct, m_cs}) begin
        failures++;
        $display("FAIL rand_cdb[%0d] got v=%b d=%h t=%0d s=%0d want v=%b d=%h t=%0d s=%0d",
                 c, cdb_valid, cdb_data, cdb_tag, cdb_sel, m_cv, m_cd, m_ct, m_cs);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_all_four();
    test_rr_wrap();
    test_streaming();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
